// File: rtl/wb_data_ram_slave_pkg.sv
// Shared types for the Wishbone data RAM slave.
// State encodings, bus widths and a byte-lane mask helper.
package wb_data_ram_slave_pkg;

  localparam int WbDataW = 32;
  localparam int WbSelW  = 4;
  localparam int WbCntW  = 4;

  typedef logic [WbDataW-1:0] wb_data_t;
  typedef logic [WbSelW-1:0]  wb_sel_t;

  typedef enum logic [1:0] {
    WbIdle = 2'd0,
    WbWait = 2'd1,
    WbResp = 2'd2
  } wb_state_e;

  function automatic wb_data_t lane_mask(
    input wb_data_t d,
    input wb_sel_t  s
  );
    wb_data_t m;
    for (int i = 0; i < WbSelW; i++) begin
      m[8*i +: 8] = s[i] ? d[8*i +: 8] : 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_data_ram_slave_ram_core.sv
// Synchronous single-port word RAM, 4 byte-write enables.
// Read-before-write: dout shows the word as it was before the edge.
module wb_ram_core #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   din,
  output logic [31:0]   dout
);

  logic [31:0] mem [2**AW];

  // one access per enabled edge: byte-lane write plus word read
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
      end
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_data_ram_slave.sv
// Wishbone classic slave over a byte-enabled data RAM.
// Adds WAIT_STATES of latency and flags out-of-range accesses.
module wb_data_ram_slave
  import wb_data_ram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  wb_state_e   st, st_nx;
  logic [WbCntW-1:0] cnt;
  logic [31:0] adr_q, dat_q;
  logic        we_q;
  wb_sel_t     sel_q;
  logic        commit, use_bus, accept;
  logic [31:0] c_adr, c_dat, off;
  logic        c_we, in_rng;
  wb_sel_t     c_sel;
  logic        rsp_ok, rsp_we;
  wb_sel_t     rsp_sel;
  logic [31:0] ram_dout;

  assign accept = wb_cyc_i && wb_stb_i &&
                  !(wb_ack_o || wb_err_o);

  // next state; the ack cycle doubles as recovery
  always_comb begin
    st_nx   = st;
    commit  = 1'b0;
    use_bus = 1'b0;
    unique case (st)
      WbIdle: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            st_nx   = WbResp;
            commit  = 1'b1;
            use_bus = 1'b1;
          end else begin
            st_nx = WbWait;
          end
        end
      end
      WbWait: begin
        if (!wb_cyc_i) begin
          st_nx = WbIdle;
        end else if (cnt == WbCntW'(1)) begin
          st_nx  = WbResp;
          commit = 1'b1;
        end
      end
      WbResp:  st_nx = WbIdle;
      default: st_nx = WbIdle;
    endcase
  end

  assign c_adr = use_bus ? wb_adr_i : adr_q;
  assign c_dat = use_bus ? wb_dat_i : dat_q;
  assign c_we  = use_bus ? wb_we_i  : we_q;
  assign c_sel = use_bus ? wb_sel_i : sel_q;

  // offset < 4 * 2^DEPTH_LOG2 is the word-index bound
  assign off    = c_adr - BASE_ADDR;
  assign in_rng = (c_adr >= BASE_ADDR) &&
                  ({1'b0, off} <
                   (33'd1 << (DEPTH_LOG2 + 2)));

  wb_ram_core #(
    .AW (DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .en   (commit && in_rng && rst),
    .we   (c_we ? c_sel : 4'h0),
    .addr (off[DEPTH_LOG2+1:2]),
    .din  (c_dat),
    .dout (ram_dout)
  );

  // state register and wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st  <= WbIdle;
      cnt <= '0;
    end else begin
      st <= st_nx;
      if (st == WbIdle && accept) begin
        cnt <= WbCntW'(WAIT_STATES);
      end else if (st == WbWait) begin
        cnt <= wb_cyc_i ? cnt - WbCntW'(1) : '0;
      end
    end
  end

  // capture request in IDLE, response info on commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      rsp_ok  <= 1'b0;
      rsp_we  <= 1'b0;
      rsp_sel <= '0;
    end else begin
      if (st == WbIdle && accept) begin
        adr_q <= wb_adr_i;
        dat_q <= wb_dat_i;
        we_q  <= wb_we_i;
        sel_q <= wb_sel_i;
      end
      if (commit) begin
        rsp_ok  <= in_rng;
        rsp_we  <= c_we;
        rsp_sel <= c_sel;
      end
    end
  end

  // registered termination and read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else if (st == WbResp) begin
      wb_ack_o <= rsp_ok;
      wb_err_o <= !rsp_ok;
      wb_dat_o <= (rsp_ok && !rsp_we) ?
                  lane_mask(ram_dout, rsp_sel) : '0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end
  end

endmodule

// File: tb/tb_wb_data_ram_slave.sv
// Directed bench for wb_data_ram_slave.
// Three instances cover wait-state, range and abort cases.
module tb_wb_data_ram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cyc, stb;
  logic        we;
  logic [31:0] adr, dati;
  logic [3:0]  sel;
  logic [31:0] dout [3];
  logic [2:0]  ack, err;
  logic [31:0] rd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_data_ram_slave #(
    .BASE_ADDR   (32'h0000_0000),
    .DEPTH_LOG2  (10),
    .WAIT_STATES (2)
  ) u_a (
    .clk (clk), .rst (rst),
    .wb_cyc_i (cyc[0]), .wb_stb_i (stb[0]),
    .wb_we_i (we), .wb_adr_i (adr),
    .wb_sel_i (sel), .wb_dat_i (dati),
    .wb_dat_o (dout[0]), .wb_ack_o (ack[0]),
    .wb_err_o (err[0])
  );

  wb_data_ram_slave #(
    .BASE_ADDR   (32'h0000_1000),
    .DEPTH_LOG2  (10),
    .WAIT_STATES (0)
  ) u_b (
    .clk (clk), .rst (rst),
    .wb_cyc_i (cyc[1]), .wb_stb_i (stb[1]),
    .wb_we_i (we), .wb_adr_i (adr),
    .wb_sel_i (sel), .wb_dat_i (dati),
    .wb_dat_o (dout[1]), .wb_ack_o (ack[1]),
    .wb_err_o (err[1])
  );

  wb_data_ram_slave #(
    .BASE_ADDR   (32'h0000_1000),
    .DEPTH_LOG2  (10),
    .WAIT_STATES (3)
  ) u_c (
    .clk (clk), .rst (rst),
    .wb_cyc_i (cyc[2]), .wb_stb_i (stb[2]),
    .wb_we_i (we), .wb_adr_i (adr),
    .wb_sel_i (sel), .wb_dat_i (dati),
    .wb_dat_o (dout[2]), .wb_ack_o (ack[2]),
    .wb_err_o (err[2])
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // one transaction; checks latency, termination kind, 1-cycle pulse
  task automatic xfer(
    input  string       tag,
    input  int          d,
    input  logic        w,
    input  logic [31:0] a,
    input  logic [3:0]  s,
    input  logic [31:0] wd,
    input  int          lat,
    input  logic        ex_err,
    output logic [31:0] r
  );
    int n;
    @(negedge clk);
    we = w; adr = a; sel = s; dati = wd;
    cyc[d] = 1'b1; stb[d] = 1'b1;
    @(posedge clk); #1;
    stb[d] = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (ack[d] || err[d]) break;
    end
    chk({tag, ".lat"}, n, lat);
    chk({tag, ".ack"}, 32'(ack[d]), 32'(!ex_err));
    chk({tag, ".err"}, 32'(err[d]), 32'(ex_err));
    r = dout[d];
    cyc[d] = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 32'(ack[d] | err[d]), 32'd0);
  endtask

  initial begin
    int t [4];
    int k;
    logic any;
    rst = 1'b0; cyc = '0; stb = '0;
    we = 1'b0; adr = '0; sel = '0; dati = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst.ack", 32'(ack[i]), 32'd0);
      chk("rst.err", 32'(err[i]), 32'd0);
      chk("rst.dat", dout[i], 32'd0);
    end
    @(negedge clk); rst = 1'b1;

    // basic write/read and byte lanes, 2 wait states
    xfer("w40", 0, 1, 32'h40, 4'hF, 32'h1234_5678, 3, 0, rd);
    chk("w40.dat", rd, 32'd0);
    xfer("r40", 0, 0, 32'h40, 4'hF, 32'h0, 3, 0, rd);
    chk("r40.dat", rd, 32'h1234_5678);
    xfer("wl", 0, 1, 32'h40, 4'b1001, 32'hAABB_CCDD, 3, 0, rd);
    xfer("rl", 0, 0, 32'h40, 4'hF, 32'h0, 3, 0, rd);
    chk("rl.dat", rd, 32'hAA34_56DD);
    xfer("rl3", 0, 0, 32'h43, 4'b0011, 32'h0, 3, 0, rd);
    chk("rl3.dat", rd, 32'h0000_56DD);

    // reset in the middle of WAIT drops the write
    xfer("w10", 0, 1, 32'h10, 4'hF, 32'h1111_1111, 3, 0, rd);
    @(negedge clk);
    we = 1'b1; adr = 32'h10; sel = 4'hF;
    dati = 32'hDEAD_BEEF;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    @(posedge clk); #1;
    stb[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid.ack", 32'(ack[0]), 32'd0);
    chk("mid.err", 32'(err[0]), 32'd0);
    chk("mid.dat", dout[0], 32'd0);
    cyc[0] = 1'b0;
    any = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      any = any | ack[0] | err[0];
    end
    chk("mid.noack", 32'(any), 32'd0);
    xfer("r10", 0, 0, 32'h10, 4'hF, 32'h0, 3, 0, rd);
    chk("r10.dat", rd, 32'h1111_1111);

    // range checks, zero wait states
    xfer("wb0", 1, 1, 32'h1000, 4'hF, 32'hCAFE_F00D, 1, 0, rd);
    xfer("wtop", 1, 1, 32'h1FFC, 4'hF, 32'h7777_0001, 1, 0, rd);
    xfer("ehi", 1, 1, 32'h2000, 4'hF, 32'hFFFF_FFFF, 1, 1, rd);
    chk("ehi.dat", rd, 32'd0);
    xfer("elo", 1, 1, 32'h0FFC, 4'hF, 32'hFFFF_FFFF, 1, 1, rd);
    chk("elo.dat", rd, 32'd0);
    xfer("erd", 1, 0, 32'h2000, 4'hF, 32'h0, 1, 1, rd);
    chk("erd.dat", rd, 32'd0);
    xfer("rb0", 1, 0, 32'h1000, 4'hF, 32'h0, 1, 0, rd);
    chk("rb0.dat", rd, 32'hCAFE_F00D);
    xfer("rtop", 1, 0, 32'h1FFC, 4'hF, 32'h0, 1, 0, rd);
    chk("rtop.dat", rd, 32'h7777_0001);

    // back-to-back reads with stb held high
    @(negedge clk);
    we = 1'b0; adr = 32'h1000; sel = 4'hF;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    k = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (ack[1]) begin
        t[k] = c;
        chk("b2b.dat", dout[1], 32'hCAFE_F00D);
        k++;
        if (k == 4) begin
          stb[1] = 1'b0;
          break;
        end
      end
    end
    chk("b2b.count", k, 4);
    chk("b2b.first", t[0], 2);
    for (int i = 1; i < 4; i++) begin
      chk("b2b.gap", t[i] - t[i-1], 3);
    end
    cyc[1] = 1'b0;
    any = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      any = any | ack[1] | err[1];
    end
    chk("b2b.quiet", 32'(any), 32'd0);

    // abort: cyc drops during WAIT
    xfer("w1004", 2, 1, 32'h1004, 4'hF, 32'h55AA_55AA, 4, 0, rd);
    @(negedge clk);
    we = 1'b1; adr = 32'h1004; sel = 4'hF;
    dati = 32'h0BAD_F00D;
    cyc[2] = 1'b1; stb[2] = 1'b1;
    @(posedge clk); #1;
    stb[2] = 1'b0;
    @(posedge clk); #1;
    cyc[2] = 1'b0;
    any = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      any = any | ack[2] | err[2];
    end
    chk("abt.quiet", 32'(any), 32'd0);
    xfer("r1004", 2, 0, 32'h1004, 4'hF, 32'h0, 4, 0, rd);
    chk("r1004.dat", rd, 32'h55AA_55AA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
